uart_cmd_framer: RTL and testbench
==================================

# uart_cmd_framer

Command-frame controller that sits directly behind the UART receiver on the motor board. It consumes the receiver's one-cycle byte strobes and sequences them through sync, command, length, payload and checksum. It validates each frame and holds it for the motor-control logic under a valid/ack handshake. Malformed, stalled or overrunning traffic is discarded and flagged with one-cycle error pulses.

## Interface
- SYNC_BYTE, 8'hAA, frame start marker
- MAX_LEN, 16, maximum payload bytes (power of two, ≤ 16)
- TIMEOUT_CLKS, 1024, inter-byte timeout in clocks (≥ 2 byte times at receiver rate)

- i_Clock  in  1  system clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_Rx_DV  in  1  one-cycle byte-valid strobe from UART receiver
- i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1
- o_Cmd_Valid  out  1  frame held, level until acked
- i_Cmd_Ack  in  1  consumer accepts held frame
- o_Cmd  out  8  command byte of held frame
- o_Len  out  5  payload length of held frame (0..MAX_LEN)
- i_Rd_Addr  in  4  payload buffer read index
- o_Rd_Data  out  8  payload byte at i_Rd_Addr, combinational read
- o_Busy  out  1  high in any state other than S_IDLE
- o_Err_Chk / o_Err_Len / o_Err_Timeout / o_Err_Overrun  out  1 each  one-cycle error pulses

## Operation
- Frame: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK. Valid iff (CMD+LEN+payload+CHK) mod 256 = 0.
- States: S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD.
- S_IDLE: byte == SYNC_BYTE -> S_CMD; any other byte ignored silently.
- S_CMD: latch CMD, sum := CMD -> S_LEN.
- S_LEN: LEN > MAX_LEN -> pulse o_Err_Len, S_IDLE. LEN = 0 -> S_CHK. Otherwise -> S_PAYLOAD with index := 0. Sum accumulates LEN.
- S_PAYLOAD: write byte to buffer[index], sum accumulates, index++. After the LEN-th byte -> S_CHK.
- S_CHK: sum+CHK = 0 -> S_HOLD, o_Cmd_Valid := 1. Otherwise pulse o_Err_Chk and go to S_IDLE; o_Cmd/o_Len unchanged.
- S_HOLD: buffer, o_Cmd and o_Len frozen.
  - i_Cmd_Ack=1: drop valid, go to S_IDLE. A byte arriving the same cycle is processed as in S_IDLE, so SYNC_BYTE -> S_CMD.
  - i_Rx_DV=1 with i_Cmd_Ack=0: byte dropped, pulse o_Err_Overrun.
- Timeout: counter clears on every accepted byte and on entry to S_CMD. It increments in S_CMD..S_CHK. At TIMEOUT_CLKS-1 without a byte: pulse o_Err_Timeout, go to S_IDLE. If a byte arrives on that same cycle, the byte wins and there is no timeout. No timeout in S_IDLE or S_HOLD.
- Sum is 8-bit wrapping. Index is 5-bit; buffer address is index[3:0].
- i_Cmd_Ack outside S_HOLD is ignored.
- i_Rd_Addr ≥ o_Len returns stale buffer contents. This is legal but not meaningful.

## Timing
- Reset (async assert, sync release): state S_IDLE; o_Cmd_Valid, o_Busy and all error pulses 0; o_Cmd=0, o_Len=0; sum, index and timeout counter 0. Buffer contents are not reset.
- o_Cmd_Valid rises the cycle after the CHK byte's i_Rx_DV, and falls the cycle after the ack edge.
- Error pulses are registered, high exactly one cycle, and asserted the cycle after the causing event.
- o_Rd_Data follows i_Rd_Addr in the same cycle.
- One byte per cycle is handled. Back-to-back i_Rx_DV on consecutive cycles is legal.
- Reset mid-frame aborts the frame; the first byte after release is treated as in S_IDLE.

## Structure
- Shared package motor_uart_pkg holds SYNC_BYTE default, MAX_LEN, the state enum encodings and the error-pulse bundle.
- One sub-module, cmd_payload_buf: 16x8 register file with a single synchronous write port and one combinational read port, no reset.
- The FSM, sum and timeout counter live in uart_cmd_framer.

## Test plan
- Good frame: AA 10 02 05 07 E2, then ack after 5 cycles. Expect o_Cmd_Valid high, o_Cmd=10, o_Len=2, buffer[0..1]=05,07; valid drops the cycle after ack.
- Bad checksum: AA 10 02 05 07 E3. Expect one o_Err_Chk pulse, no valid, o_Busy=0 afterwards.
- Length error: AA 20 11. Expect o_Err_Len. A following AA 20 00 E0 yields valid with o_Len=0.
- Timeout: AA 30, then silence for TIMEOUT_CLKS cycles. Expect one o_Err_Timeout pulse, return to S_IDLE. Repeat with a byte on cycle TIMEOUT_CLKS-1: no pulse.
- Overrun and ack collision: while holding a frame, send byte 55 -> o_Err_Overrun and frame unchanged. Then send AA on the same cycle as i_Cmd_Ack -> valid drops, o_Busy stays 1 (S_CMD).
- Reset mid-payload: assert i_Reset_n=0 during the third payload byte. All outputs return to reset values; a subsequent good frame decodes correctly.

Source files
------------

// File: rtl/motor_uart_pkg.sv
// Shared definitions for the motor-board UART command path: framing constants,
// framer state encoding and the error-pulse bundle.
package motor_uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hAA;
    localparam int         MAX_LEN          = 16;
    localparam int         TIMEOUT_CLKS_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_HOLD    = 3'd5
    } state_e;

    typedef struct packed {
        logic chk;
        logic len;
        logic timeout;
        logic overrun;
    } err_t;

    // Frame checksum is a plain 8-bit wrapping sum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// 16x8 payload register file: one synchronous write port, one combinational
// read port, deliberately without reset.
module cmd_payload_buf (
    input  logic       i_Clock,
    input  logic       i_Wr_En,
    input  logic [3:0] i_Wr_Addr,
    input  logic [7:0] i_Wr_Data,
    input  logic [3:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data
);

    logic [7:0] mem_q [16];

    // Payload byte write
    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            mem_q[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule

// File: rtl/uart_cmd_framer.sv
// Sequences UART byte strobes through sync/cmd/len/payload/checksum, holds a
// validated frame under valid/ack and flags discarded traffic with error pulses.
module uart_cmd_framer
    import motor_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Cmd_Valid,
    input  logic       i_Cmd_Ack,
    output logic [7:0] o_Cmd,
    output logic [4:0] o_Len,
    input  logic [3:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data,
    output logic       o_Busy,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overrun
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    state_e        state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    cmd_w_q, cmd_w_d;
    logic [4:0]    len_w_q, len_w_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [4:0]    len_q, len_d;
    logic          valid_q, busy_q;
    err_t          err_q, err_d;
    logic          wr_en_s;

    // Working cmd/len are kept apart from the held copy so a rejected frame
    // never disturbs what the consumer last saw.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            sum_q   <= 8'h00;
            idx_q   <= 5'd0;
            tmo_q   <= '0;
            cmd_w_q <= 8'h00;
            len_w_q <= 5'd0;
            cmd_q   <= 8'h00;
            len_q   <= 5'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            cmd_w_q <= cmd_w_d;
            len_w_q <= len_w_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            valid_q <= (state_d == S_HOLD);
            busy_q  <= (state_d != S_IDLE);
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and error detection
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        cmd_w_d = cmd_w_q;
        len_w_d = len_w_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        err_d   = '0;
        wr_en_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (i_Rx_DV) begin
                    cmd_w_d = i_Rx_Byte;
                    sum_d   = i_Rx_Byte;
                    state_d = S_LEN;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    sum_d = sum8(sum_q, i_Rx_Byte);
                    if (i_Rx_Byte > 8'(MAX_LEN)) begin
                        err_d.len = 1'b1;
                        state_d   = S_IDLE;
                    end else if (i_Rx_Byte == 8'h00) begin
                        len_w_d = 5'd0;
                        state_d = S_CHK;
                    end else begin
                        len_w_d = i_Rx_Byte[4:0];
                        idx_d   = 5'd0;
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en_s = 1'b1;
                    sum_d   = sum8(sum_q, i_Rx_Byte);
                    idx_d   = idx_q + 5'd1;
                    if (idx_q == (len_w_q - 5'd1)) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (sum8(sum_q, i_Rx_Byte) == 8'h00) begin
                        cmd_d   = cmd_w_q;
                        len_d   = len_w_q;
                        state_d = S_HOLD;
                    end else begin
                        err_d.chk = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            S_HOLD: begin
                if (i_Cmd_Ack) begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_d = S_CMD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (i_Rx_DV) begin
                    err_d.overrun = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-byte timeout; a byte on the terminal cycle wins over the timeout.
        if ((state_q == S_CMD) || (state_q == S_LEN) ||
            (state_q == S_PAYLOAD) || (state_q == S_CHK)) begin
            if (i_Rx_DV) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                err_d.timeout = 1'b1;
                tmo_d         = '0;
                state_d       = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    cmd_payload_buf u_buf (
        .i_Clock   (i_Clock),
        .i_Wr_En   (wr_en_s),
        .i_Wr_Addr (idx_q[3:0]),
        .i_Wr_Data (i_Rx_Byte),
        .i_Rd_Addr (i_Rd_Addr),
        .o_Rd_Data (o_Rd_Data)
    );

    assign o_Cmd_Valid   = valid_q;
    assign o_Busy        = busy_q;
    assign o_Cmd         = cmd_q;
    assign o_Len         = len_q;
    assign o_Err_Chk     = err_q.chk;
    assign o_Err_Len     = err_q.len;
    assign o_Err_Timeout = err_q.timeout;
    assign o_Err_Overrun = err_q.overrun;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed self-checking bench for uart_cmd_framer with hand-computed frames.
module tb_uart_cmd_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       cmd_valid, busy, e_chk, e_len, e_to, e_ovr;
    logic [7:0] cmd, rd_data;
    logic [4:0] len;

    int vectors = 0;
    int miscompares = 0;
    int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

    uart_cmd_framer dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Cmd_Valid   (cmd_valid),
        .i_Cmd_Ack     (ack),
        .o_Cmd         (cmd),
        .o_Len         (len),
        .i_Rd_Addr     (rd_addr),
        .o_Rd_Data     (rd_data),
        .o_Busy        (busy),
        .o_Err_Chk     (e_chk),
        .o_Err_Len     (e_len),
        .o_Err_Timeout (e_to),
        .o_Err_Overrun (e_ovr)
    );

    always #5 clk = ~clk;

    // Count high cycles of each error pulse
    always @(negedge clk) begin
        if (e_chk) n_chk++;
        if (e_len) n_len++;
        if (e_to)  n_to++;
        if (e_ovr) n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic do_ack();
        ack = 1'b1;
        wait_cyc(1);
        ack = 1'b0;
    endtask

    initial begin
        // Reset state
        wait_cyc(2);
        chk("rst_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cmd", {24'h0, cmd}, 32'h0);
        chk("rst_len", {27'h0, len}, 32'h0);
        chk("rst_errs", {28'h0, e_chk, e_len, e_to, e_ovr}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Good frame AA 10 02 05 07 E2
        send(8'hAA); send(8'h10); send(8'h02); send(8'h05); send(8'h07);
        chk("good_busy", {31'h0, busy}, 32'h1);
        chk("good_pre_valid", {31'h0, cmd_valid}, 32'h0);
        send(8'hE2);
        chk("good_valid", {31'h0, cmd_valid}, 32'h1);
        chk("good_cmd", {24'h0, cmd}, 32'h10);
        chk("good_len", {27'h0, len}, 32'h2);
        rd("good_buf0", 4'd0, 8'h05);
        rd("good_buf1", 4'd1, 8'h07);
        wait_cyc(5);
        chk("good_hold", {31'h0, cmd_valid}, 32'h1);
        do_ack();
        chk("good_acked", {31'h0, cmd_valid}, 32'h0);
        chk("good_idle", {31'h0, busy}, 32'h0);

        // Bad checksum AA 10 02 05 07 E3
        send(8'hAA); send(8'h10); send(8'h02); send(8'h05); send(8'h07); send(8'hE3);
        chk("badchk_pulse", {31'h0, e_chk}, 32'h1);
        chk("badchk_valid", {31'h0, cmd_valid}, 32'h0);
        wait_cyc(2);
        chk("badchk_idle", {31'h0, busy}, 32'h0);
        chk("badchk_count", n_chk, 32'd1);
        chk("badchk_cmd_kept", {24'h0, cmd}, 32'h10);

        // Length error AA 20 11, then zero-length frame AA 20 00 E0
        send(8'hAA); send(8'h20); send(8'h11);
        chk("len_pulse", {31'h0, e_len}, 32'h1);
        chk("len_idle", {31'h0, busy}, 32'h0);
        send(8'hAA); send(8'h20); send(8'h00); send(8'hE0);
        chk("len0_valid", {31'h0, cmd_valid}, 32'h1);
        chk("len0_cmd", {24'h0, cmd}, 32'h20);
        chk("len0_len", {27'h0, len}, 32'h0);
        chk("len_count", n_len, 32'd1);
        do_ack();

        // Timeout: AA 30 then silence
        send(8'hAA); send(8'h30);
        wait_cyc(1023);
        chk("to_not_yet", {31'h0, e_to}, 32'h0);
        chk("to_busy_before", {31'h0, busy}, 32'h1);
        wait_cyc(1);
        chk("to_pulse", {31'h0, e_to}, 32'h1);
        chk("to_idle", {31'h0, busy}, 32'h0);
        wait_cyc(3);
        chk("to_count", n_to, 32'd1);

        // Byte on the terminal cycle beats the timeout: AA 30 00 D0
        send(8'hAA); send(8'h30);
        wait_cyc(1023);
        send(8'h00);
        chk("to_win_busy", {31'h0, busy}, 32'h1);
        send(8'hD0);
        chk("to_win_valid", {31'h0, cmd_valid}, 32'h1);
        chk("to_win_count", n_to, 32'd1);
        do_ack();

        // Maximum length frame: AA 60 10, payload 00..0F, CHK 18
        send(8'hAA); send(8'h60); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h18);
        chk("max_valid", {31'h0, cmd_valid}, 32'h1);
        chk("max_len", {27'h0, len}, 32'd16);
        rd("max_buf15", 4'd15, 8'h0F);
        rd("max_buf7", 4'd7, 8'h07);

        // Overrun while holding
        send(8'h55);
        chk("ovr_pulse", {31'h0, e_ovr}, 32'h1);
        chk("ovr_valid", {31'h0, cmd_valid}, 32'h1);
        chk("ovr_cmd", {24'h0, cmd}, 32'h60);
        chk("ovr_len", {27'h0, len}, 32'd16);
        rd("ovr_buf15", 4'd15, 8'h0F);

        // Ack collides with a sync byte
        ack = 1'b1;
        send(8'hAA);
        ack = 1'b0;
        chk("coll_valid", {31'h0, cmd_valid}, 32'h0);
        chk("coll_busy", {31'h0, busy}, 32'h1);
        chk("ovr_count", n_ovr, 32'd1);

        // Reset during third payload byte (frame continues from S_CMD)
        send(8'h40); send(8'h03); send(8'h11); send(8'h22);
        rx_dv = 1'b1;
        rx_byte = 8'h33;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        chk("mrst_valid", {31'h0, cmd_valid}, 32'h0);
        chk("mrst_cmd", {24'h0, cmd}, 32'h0);
        chk("mrst_len", {27'h0, len}, 32'h0);
        wait_cyc(2);
        rx_dv = 1'b0;
        rst_n = 1'b1;
        wait_cyc(1);
        chk("mrst_errs", {28'h0, e_chk, e_len, e_to, e_ovr}, 32'h0);

        // Good frame after reset: AA 50 01 99 16
        send(8'hAA); send(8'h50); send(8'h01); send(8'h99); send(8'h16);
        chk("post_valid", {31'h0, cmd_valid}, 32'h1);
        chk("post_cmd", {24'h0, cmd}, 32'h50);
        chk("post_len", {27'h0, len}, 32'h1);
        rd("post_buf0", 4'd0, 8'h99);
        do_ack();
        chk("post_idle", {31'h0, busy}, 32'h0);
        chk("final_chk_count", n_chk, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
